// File: rtl/delay_line_flow_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : delay_line_flow_ctrl_pkg
//  Description : Shared definitions for the delay-line flow controller.
//                Provides the 2-bit controller state encoding
//                (ST_IDLE / ST_RUN / ST_FLUSH / ST_CLEAR) and the legal
//                range of the DELAY parameter.
//  Revision    : 1.0 - initial release
// ============================================================================
package delay_line_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_CLEAR = 2'd3
    } ctrl_state_t;

    localparam int DELAY_MIN = 1;
    localparam int DELAY_MAX = 4096;

endpackage : delay_line_flow_ctrl_pkg
`default_nettype wire

// File: rtl/delay_line_flow_ctrl_valid_bit_shift.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : valid_bit_shift
//  Description : DEPTH x 1-bit shift register shadowing the external delay
//                line. Stage 0 loads din on each enabled cycle, every other
//                stage takes its predecessor. The last stage is the tail tap.
//  Ports       : clk  - clock
//                grst - synchronous active-high reset
//                en   - advance one stage
//                clr  - synchronous clear of all stages (wins over en)
//                din  - valid bit entering stage 0
//                tail - valid bit of the last stage
//  Revision    : 1.0 - initial release
// ============================================================================
module valid_bit_shift #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic grst,
    input  logic en,
    input  logic clr,
    input  logic din,
    output logic tail
);

    logic [DEPTH-1:0] bits;

    // A single-stage line has no predecessor slice, so it gets its own branch.
    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (grst || clr) begin
                    bits <= '0;
                end else if (en) begin
                    bits <= din;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (grst || clr) begin
                    bits <= '0;
                end else if (en) begin
                    bits <= {bits[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign tail = bits[DEPTH-1];

endmodule : valid_bit_shift
`default_nettype wire

// File: rtl/delay_line_flow_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : delay_line_flow_ctrl
//  Description : Valid/ready flow controller for one enable-gated external
//                delay line of DELAY stages. Drives the line's enable and
//                clear, tracks per-stage validity, supports back-pressure,
//                bubble-injecting flush and synchronous clear.
//  Ports       : clk, grst              - clock, sync active-high reset
//                in_valid / in_ready    - producer handshake
//                out_valid / out_ready  - consumer handshake
//                flush_req, clr_req     - drain / discard requests (pulses)
//                dl_en, dl_rst          - delay-line advance / clear
//                occupancy              - valid samples held in the line
//                flush_done             - pulse on flush completion
//                busy                   - controller not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_line_flow_ctrl
    import delay_line_flow_ctrl_pkg::*;
#(
    parameter int DELAY = 4,
    parameter bit TIMED = 1'b0
) (
    input  logic                         clk,
    input  logic                         grst,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush_req,
    input  logic                         clr_req,
    output logic                         dl_en,
    output logic                         dl_rst,
    output logic [$clog2(DELAY+1)-1:0]   occupancy,
    output logic                         flush_done,
    output logic                         busy
);

    localparam int OCC_W = $clog2(DELAY + 1);

    ctrl_state_t      state;
    ctrl_state_t      state_nx;
    logic             tail_v;
    logic             stall;
    logic             accepting;
    logic             push;
    logic             pop;
    logic             advance;
    logic             clr_now;
    logic [OCC_W-1:0] occ_nx;

    // Only IDLE and RUN take new samples; a stalled tail blocks everything.
    assign stall     = tail_v & ~out_ready;
    assign accepting = (state == ST_IDLE) || (state == ST_RUN);
    assign in_ready  = ~stall & accepting;
    assign push      = in_valid & in_ready;

    always_comb begin
        advance = 1'b0;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (TIMED) begin
                    advance = ~stall & (in_valid | (occupancy != '0));
                end else begin
                    advance = push;
                end
            end
            ST_FLUSH: advance = ~stall;
            default:  advance = 1'b0;
        endcase
    end

    assign pop = advance & tail_v;

    always_comb begin
        occ_nx = occupancy;
        if (push && !pop) begin
            occ_nx = occupancy + OCC_W'(1);
        end else if (pop && !push) begin
            occ_nx = occupancy - OCC_W'(1);
        end
    end

    // Contents are discarded in the cycle clr_req is seen, and held empty
    // while the CLEAR state pulses dl_rst into the data line.
    assign clr_now = clr_req | (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (grst) begin
            occupancy <= '0;
        end else if (clr_now) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_nx;
        end
    end

    valid_bit_shift #(
        .DEPTH (DELAY)
    ) u_valid_shift (
        .clk  (clk),
        .grst (grst),
        .en   (advance),
        .clr  (clr_now),
        .din  (push),
        .tail (tail_v)
    );

    always_ff @(posedge clk) begin
        if (grst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        flush_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush_req) begin
                    state_nx = ST_FLUSH;
                end else if (push) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_req) begin
                    state_nx = ST_FLUSH;
                end else if (occ_nx == '0) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (occ_nx == '0) begin
                    state_nx   = ST_IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        // Clear overrides everything, including a flush completing this cycle.
        if (clr_req) begin
            state_nx   = ST_CLEAR;
            flush_done = 1'b0;
        end
    end

    assign out_valid = tail_v;
    assign dl_en     = advance;
    assign dl_rst    = (state == ST_CLEAR);
    assign busy      = (state != ST_IDLE);

endmodule : delay_line_flow_ctrl
`default_nettype wire
